// File: rtl/bus_grant_ctrl_pkg.sv
// Shared definitions for the bus grant controller and its round-robin arbiter:
// FSM state encoding, channel addresses and default sizing.
package bus_grant_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_LATCH = 3'd2,
    ST_GRANT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] CH0 = 2'b00;
  localparam logic [1:0] CH1 = 2'b01;
  localparam logic [1:0] CH2 = 2'b10;
  localparam logic [1:0] CH3 = 2'b11;

  localparam int NUM_CLIENTS_DEF = 4;
  localparam int DATA_W_DEF      = 8;

endpackage

// File: rtl/bus_grant_ctrl_timeout_counter.sv
// GRANT-phase timeout counter: synchronous clear, count enable, saturates at
// TIMEOUT_CYCLES-1 and flags that terminal count.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] cnt;

  assign terminal = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clear)
      cnt <= '0;
    else if (enable && !terminal)
      cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/bus_grant_ctrl.sv
// Bus grant controller: pulses the arbiter, latches the winning client and runs
// a req/ack transfer of its data to the server, with per-transfer timeout.
module bus_grant_ctrl
  import bus_grant_ctrl_pkg::*;
#(
  parameter int NUM_CLIENTS    = NUM_CLIENTS_DEF,
  parameter int ADDR_W         = 2,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CLIENTS-1:0]        client_rq,
  input  logic [NUM_CLIENTS*DATA_W-1:0] client_data,
  input  logic [ADDR_W-1:0]             arb_address,
  output logic                          arb_enable,
  output logic                          server_req,
  output logic [ADDR_W-1:0]             server_addr,
  output logic [DATA_W-1:0]             server_data,
  input  logic                          server_ack,
  output logic [NUM_CLIENTS-1:0]        client_grant,
  output logic [NUM_CLIENTS-1:0]        client_done,
  output logic                          timeout_err
);

  state_t              state, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   client_slices [NUM_CLIENTS];
  logic                rq_valid;
  logic                cnt_clear, cnt_en, cnt_tc;
  logic                timeout_err_d;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CLIENTS; i++)
      client_slices[i] = client_data[i*DATA_W +: DATA_W];
  end

  // Out-of-range addresses behave like a withdrawn request.
  assign rq_valid = (32'(arb_address) < NUM_CLIENTS) && client_rq[arb_address];

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .terminal(cnt_tc)
  );

  always_comb begin
    state_d       = state;
    addr_d        = addr_q;
    data_d        = data_q;
    cnt_clear     = 1'b0;
    cnt_en        = 1'b0;
    timeout_err_d = 1'b0;
    case (state)
      ST_IDLE: if (|client_rq) state_d = ST_ARB;
      ST_ARB:  state_d = ST_LATCH;
      ST_LATCH: begin
        addr_d = arb_address;
        data_d = client_slices[arb_address];
        if (rq_valid) begin
          state_d   = ST_GRANT;
          cnt_clear = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        cnt_en = 1'b1;
        // Ack takes priority over a coincident terminal count.
        if (server_ack) begin
          state_d = ST_DONE;
        end else if (cnt_tc) begin
          state_d       = ST_IDLE;
          timeout_err_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      state  <= state_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  // Outputs are registered from the next state so they line up with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arb_enable   <= 1'b0;
      server_req   <= 1'b0;
      server_addr  <= '0;
      server_data  <= '0;
      client_grant <= '0;
      client_done  <= '0;
      timeout_err  <= 1'b0;
    end else begin
      arb_enable   <= (state_d == ST_ARB);
      server_req   <= (state_d == ST_GRANT);
      server_addr  <= (state_d == ST_GRANT) ? addr_d : '0;
      server_data  <= (state_d == ST_GRANT) ? data_d : '0;
      client_grant <= (state_d == ST_GRANT) ? (NUM_CLIENTS'(1) << addr_d) : '0;
      client_done  <= (state_d == ST_DONE)  ? (NUM_CLIENTS'(1) << addr_d) : '0;
      timeout_err  <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_bus_grant_ctrl.sv
// Self-checking bench for bus_grant_ctrl: a cycle-by-cycle vector table plus
// hand-written reset, timeout, ack-on-terminal and round-robin sequences.
module tb_bus_grant_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  client_rq;
  logic [31:0] client_data;
  logic [1:0]  arb_address;
  logic        arb_enable;
  logic        server_req;
  logic [1:0]  server_addr;
  logic [7:0]  server_data;
  logic        server_ack;
  logic [3:0]  client_grant;
  logic [3:0]  client_done;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_grant_ctrl #(
    .NUM_CLIENTS   (4),
    .ADDR_W        (2),
    .DATA_W        (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .client_rq   (client_rq),
    .client_data (client_data),
    .arb_address (arb_address),
    .arb_enable  (arb_enable),
    .server_req  (server_req),
    .server_addr (server_addr),
    .server_data (server_data),
    .server_ack  (server_ack),
    .client_grant(client_grant),
    .client_done (client_done),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic [3:0] rq;
    logic [1:0] addr;
    logic       ack;
    logic       arb_en;
    logic       req;
    logic [1:0] saddr;
    logic [7:0] sdata;
    logic [3:0] grant;
    logic [3:0] done;
    logic       terr;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic logic [31:0] pack_out();
    return {11'd0, arb_enable, server_req, server_addr, server_data,
            client_grant, client_done, timeout_err};
  endfunction

  function automatic logic [31:0] pack_exp(input vec_t v);
    return {11'd0, v.arb_en, v.req, v.saddr, v.sdata, v.grant, v.done, v.terr};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request through IDLE, ARB and LATCH; returns in the first GRANT cycle.
  task automatic start_xfer(input logic [3:0] rq, input logic [1:0] addr);
    client_rq  = rq;
    server_ack = 1'b0;
    tick();
    arb_address = addr;
    tick();
    tick();
    check("enter_grant", {31'd0, server_req}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] orig;
    logic [3:0]  done_val [4];
    int          done_cyc [4];
    int          ndone;
    int          both_bad;
    int          bad;
    int          n;
    logic [1:0]  rr;

    //          rq       addr   ack   en    req   sa     sd     grant    done     terr
    vecs[0]  = '{4'b0100, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 4'b0000, 4'b0000, 1'b0};
    vecs[1]  = '{4'b0100, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 4'b0000, 4'b0000, 1'b0};
    vecs[2]  = '{4'b0100, 2'b10, 1'b0, 1'b0, 1'b1, 2'b10, 8'hA5, 4'b0100, 4'b0000, 1'b0};
    vecs[3]  = '{4'b0100, 2'b10, 1'b0, 1'b0, 1'b1, 2'b10, 8'hA5, 4'b0100, 4'b0000, 1'b0};
    vecs[4]  = '{4'b0100, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 4'b0000, 4'b0100, 1'b0};
    vecs[5]  = '{4'b0000, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 4'b0000, 4'b0000, 1'b0};
    vecs[6]  = '{4'b0000, 2'b10, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 4'b0000, 4'b0000, 1'b0};
    vecs[7]  = '{4'b0010, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 4'b0000, 4'b0000, 1'b0};
    vecs[8]  = '{4'b0000, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 4'b0000, 4'b0000, 1'b0};
    vecs[9]  = '{4'b0000, 2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 4'b0000, 4'b0000, 1'b0};
    vecs[10] = '{4'b0000, 2'b01, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 4'b0000, 4'b0000, 1'b0};
    vecs[11] = '{4'b1000, 2'b01, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 4'b0000, 4'b0000, 1'b0};
    vecs[12] = '{4'b1000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 4'b0000, 4'b0000, 1'b0};
    vecs[13] = '{4'b1000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 4'b0000, 4'b0000, 1'b0};
    vecs[14] = '{4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 4'b0000, 4'b0000, 1'b0};
    vecs[15] = '{4'b0001, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 8'h00, 4'b0000, 4'b0000, 1'b0};
    vecs[16] = '{4'b0001, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 4'b0000, 4'b0000, 1'b0};
    vecs[17] = '{4'b0001, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 8'h11, 4'b0001, 4'b0000, 1'b0};
    vecs[18] = '{4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 4'b0000, 4'b0001, 1'b0};
    vecs[19] = '{4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 4'b0000, 4'b0000, 1'b0};

    reset       = 1'b1;
    client_rq   = '0;
    client_data = 32'h44A5_2211;
    arb_address = '0;
    server_ack  = 1'b0;
    tick();
    tick();
    check("reset_state", pack_out(), 32'd0);
    reset = 1'b0;
    tick();
    check("idle_after_reset", pack_out(), 32'd0);

    // Each vector's inputs are held for one cycle; outputs checked after the edge.
    for (int i = 0; i < NV; i++) begin
      client_rq   = vecs[i].rq;
      arb_address = vecs[i].addr;
      server_ack  = vecs[i].ack;
      tick();
      check($sformatf("vec%0d", i), pack_out(), pack_exp(vecs[i]));
    end
    server_ack = 1'b0;

    // Reset asserted mid-GRANT clears outputs without waiting for a clock edge.
    start_xfer(4'b0001, 2'b00);
    tick();
    #3 reset = 1'b1;
    #1 check("rst_mid_grant", pack_out(), 32'd0);
    client_rq = '0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check("rst_release_idle", pack_out(), 32'd0);
    client_rq = 4'b0001;
    tick();
    check("rst_then_arb", {31'd0, arb_enable}, 32'd1);
    client_rq = '0;
    tick();
    tick();

    // Never acked: 16 GRANT cycles then a single timeout pulse; request drop does not abort.
    start_xfer(4'b0001, 2'b00);
    client_rq = '0;
    n   = 0;
    bad = 0;
    for (int i = 0; i < 40 && server_req; i++) begin
      n++;
      if (timeout_err || client_done != 4'b0000 || client_grant != 4'b0001) bad++;
      tick();
    end
    check("timeout_req_cycles", n, 32'd16);
    check("timeout_grant_phase", bad, 32'd0);
    check("timeout_pulse", {31'd0, timeout_err}, 32'd1);
    check("timeout_no_done", {28'd0, client_done}, 32'd0);
    tick();
    check("timeout_pulse_end", {31'd0, timeout_err}, 32'd0);
    check("timeout_back_idle", pack_out(), 32'd0);

    // Ack on the 16th GRANT cycle beats the timeout.
    start_xfer(4'b1000, 2'b11);
    client_rq = '0;
    bad = 0;
    for (int k = 1; k < 16; k++) begin
      if (!server_req || timeout_err) bad++;
      tick();
    end
    check("ack16_still_grant", {31'd0, server_req}, 32'd1);
    check("ack16_prefix", bad, 32'd0);
    server_ack = 1'b1;
    tick();
    server_ack = 1'b0;
    check("ack16_done", {28'd0, client_done}, 32'b1000);
    check("ack16_no_terr", {31'd0, timeout_err}, 32'd0);
    check("ack16_req_low", {31'd0, server_req}, 32'd0);
    tick();
    check("ack16_after", pack_out(), 32'd0);

    // All clients requesting, arbiter rotating 00..11, ack in the first GRANT cycle.
    orig        = 32'h8463_4221;
    client_data = orig;
    client_rq   = 4'b1111;
    arb_address = 2'b00;
    rr          = 2'b00;
    ndone       = 0;
    both_bad    = 0;
    for (int c = 0; c < 80 && ndone < 4; c++) begin
      tick();
      server_ack = 1'b0;
      if (client_grant != 4'b0000 && client_done != 4'b0000) both_bad++;
      if (arb_enable) begin
        arb_address = rr;
        rr          = rr + 2'd1;
        client_data = orig;
      end
      if (server_req) begin
        check($sformatf("rr_addr%0d", ndone), {30'd0, server_addr}, ndone);
        check($sformatf("rr_data%0d", ndone), {24'd0, server_data}, {24'd0, orig[ndone*8 +: 8]});
        server_ack  = 1'b1;
        client_data = ~orig;
      end
      if (client_done != 4'b0000) begin
        done_val[ndone] = client_done;
        done_cyc[ndone] = c;
        ndone++;
      end
    end
    client_rq  = '0;
    server_ack = 1'b0;
    check("rr_count", ndone, 32'd4);
    for (int i = 0; i < 4 && i < ndone; i++)
      check($sformatf("rr_done%0d", i), {28'd0, done_val[i]}, 32'd1 << i);
    for (int i = 1; i < 4 && i < ndone; i++)
      check($sformatf("rr_spacing%0d", i), done_cyc[i] - done_cyc[i-1], 32'd5);
    check("rr_grant_done_excl", both_bad, 32'd0);
    tick();
    tick();
    check("rr_final_idle", pack_out(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
